// File: rtl/multicycle_adder_pkg.sv
// rtl/multicycle_adder_pkg.sv - shared FSM encodings and sizing helpers for the multi-cycle adder
//
// Contents:
//   state_t     : 2-bit FSM encoding (ST_IDLE, ST_RUN, ST_DONE)
//   idx_width() : width of the chunk index, clog2(nchunk) with a floor of 1 bit
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a 1-bit index register so the
    // datapath is written the same way for every CHUNK/WIDTH pair.
    function automatic int idx_width(input int nchunk);
        if (nchunk <= 1) begin
            return 1;
        end
        return $clog2(nchunk);
    endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// rtl/multicycle_adder_chunk_adder.sv - combinational N-bit ripple-carry chunk adder
//
// Ports:
//   a, b  in  N  chunk operands (b already inverted by the caller for subtraction)
//   cin   in  1  carry into bit 0
//   s     out N  chunk sum
//   cout  out 1  carry out of bit N-1
//   cmsb  out 1  carry into bit N-1 (used with cout for signed overflow)
module chunk_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    always_comb begin
        logic [N:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[N];
        cmsb = c[N-1];
    end

endmodule

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - multi-cycle adder/subtractor, CHUNK bits per clock
//
// Parameters:
//   WIDTH  operand/result width, a multiple of CHUNK
//   CHUNK  bits added per clock (1..WIDTH); NCHUNK = WIDTH/CHUNK compute cycles
//
// Ports:
//   clock   in  1      rising-edge clock
//   resetn  in  1      asynchronous active-low reset
//   start   in  1      request, sampled only while ready=1
//   sub     in  1      0: A+B, 1: A-B (captured with start)
//   op_a    in  WIDTH  operand A (captured with start)
//   op_b    in  WIDTH  operand B (captured with start)
//   ready   out 1      a start will be accepted this cycle
//   done    out 1      one-cycle pulse, result valid
//   sum     out WIDTH  result, held until the next run updates it
//   cout    out 1      carry out of the MSB (sub: 1 = no borrow)
//   ovf     out 1      signed overflow
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);

    localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    state_t          state;
    state_t          state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [IW-1:0]    idx_q;

    logic             accept;
    logic             running;
    logic             last_chunk;
    int               base;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic             cmsb_chunk;

    // start is only honoured outside RUN, so a request mid-operation is dropped
    assign running    = (state == ST_RUN);
    assign accept     = start && !running;
    assign last_chunk = running && (idx_q == IDX_LAST);

    // Bit offset of the chunk being worked on this cycle
    assign base    = int'(idx_q) * CHUNK;
    assign a_chunk = a_q[base +: CHUNK];
    assign b_chunk = b_q[base +: CHUNK];

    chunk_adder #(
        .N (CHUNK)
    ) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .s    (s_chunk),
        .cout (c_chunk),
        .cmsb (cmsb_chunk)
    );

    // FSM: state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:           state_nxt = (idx_q == IDX_LAST) ? ST_DONE : ST_RUN;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready = 1'b1;
        done  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                done  = 1'b0;
            end
            ST_RUN: begin
                ready = 1'b0;
                done  = 1'b0;
            end
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b1;
                done  = 1'b0;
            end
        endcase
    end

    // Datapath. Subtraction is A + ~B + 1: B is inverted at capture and the
    // +1 enters as the initial carry, so the chunk loop is identical for both.
    // sum/cout/ovf are only touched while running so they hold between runs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx_q   <= '0;
        end else if (running) begin
            sum_q[base +: CHUNK] <= s_chunk;
            carry_q              <= c_chunk;
            idx_q                <= idx_q + IDX_ONE;
            if (last_chunk) begin
                cout_q <= c_chunk;
                ovf_q  <= c_chunk ^ cmsb_chunk;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - directed and randomized checks of multicycle_adder over four configurations
module tb_multicycle_adder;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        sub;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic [3:0]  rdy;
    logic [3:0]  dn;
    logic [3:0]  co;
    logic [3:0]  ov;
    logic [15:0] s0;
    logic [7:0]  s1;
    logic [15:0] s2;
    logic [31:0] s3;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-configuration results of the most recent run_op
    int          lat  [4];
    int          dcnt [4];
    logic [31:0] rs   [4];
    logic        rc   [4];
    logic        rv   [4];

    always #5 clock = ~clock;

    // k=0: (16,4)  k=1: (8,1)  k=2: (16,16)  k=3: (32,8)
    multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_16_4 (
        .clock(clock), .resetn(resetn), .start(start), .sub(sub),
        .op_a(op_a[15:0]), .op_b(op_b[15:0]),
        .ready(rdy[0]), .done(dn[0]), .sum(s0), .cout(co[0]), .ovf(ov[0]));
    multicycle_adder #(.WIDTH(8), .CHUNK(1)) u_8_1 (
        .clock(clock), .resetn(resetn), .start(start), .sub(sub),
        .op_a(op_a[7:0]), .op_b(op_b[7:0]),
        .ready(rdy[1]), .done(dn[1]), .sum(s1), .cout(co[1]), .ovf(ov[1]));
    multicycle_adder #(.WIDTH(16), .CHUNK(16)) u_16_16 (
        .clock(clock), .resetn(resetn), .start(start), .sub(sub),
        .op_a(op_a[15:0]), .op_b(op_b[15:0]),
        .ready(rdy[2]), .done(dn[2]), .sum(s2), .cout(co[2]), .ovf(ov[2]));
    multicycle_adder #(.WIDTH(32), .CHUNK(8)) u_32_8 (
        .clock(clock), .resetn(resetn), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b),
        .ready(rdy[3]), .done(dn[3]), .sum(s3), .cout(co[3]), .ovf(ov[3]));

    function automatic int cfg_w(input int k);
        case (k)
            0: return 16;
            1: return 8;
            2: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_nc(input int k);
        case (k)
            0: return 4;
            1: return 8;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] sumv(input int k);
        case (k)
            0: return {16'h0, s0};
            1: return {24'h0, s1};
            2: return {16'h0, s2};
            default: return s3;
        endcase
    endfunction

    // Reference: plain two's-complement arithmetic; overflow from operand/result signs
    function automatic logic [33:0] model(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] full;
        logic        c;
        logic        v;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'h0, a} & mask;
        bm   = (s ? ~{32'h0, b} : {32'h0, b}) & mask;
        full = am + bm + {63'h0, s};
        c    = full[w];
        v    = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
        return {v, c, full[31:0] & mask[31:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_all_ready();
        int n;
        n = 0;
        @(negedge clock);
        while (rdy != 4'hF && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (rdy != 4'hF) check("ready_timeout", 32'(rdy), 32'hF);
    endtask

    // Launch one operation on all instances; latency counts the accepting edge as 1
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [3:0] seen;
        int         edges;
        wait_all_ready();
        start = 1'b1;
        sub   = s;
        op_a  = a;
        op_b  = b;
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        start = 1'b0;
        seen  = '0;
        for (int k = 0; k < 4; k++) begin
            lat[k]  = -1;
            dcnt[k] = 0;
        end
        while (seen != 4'hF && edges < 40) begin
            for (int k = 0; k < 4; k++) begin
                if (dn[k]) dcnt[k]++;
                if (!seen[k] && dn[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = edges;
                    rs[k]   = sumv(k);
                    rc[k]   = co[k];
                    rv[k]   = ov[k];
                end
            end
            if (seen != 4'hF) begin
                @(posedge clock);
                edges++;
                @(negedge clock);
            end
        end
        check("all_done", 32'(seen), 32'hF);
    endtask

    task automatic check_main(input string tag, input logic [15:0] es, input logic ec, input logic ev);
        check({tag, "_sum"},  rs[0], {16'h0, es});
        check({tag, "_cout"}, 32'(rc[0]), 32'(ec));
        check({tag, "_ovf"},  32'(rv[0]), 32'(ev));
        check({tag, "_lat"},  32'(lat[0]), 32'd5);
    endtask

    task automatic check_model(input int k, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [33:0] m;
        m = model(cfg_w(k), s, a, b);
        check($sformatf("rnd%0d_sum", k),  rs[k], m[31:0]);
        check($sformatf("rnd%0d_cout", k), 32'(rc[k]), 32'(m[32]));
        check($sformatf("rnd%0d_ovf", k),  32'(rv[k]), 32'(m[33]));
        check($sformatf("rnd%0d_lat", k),  32'(lat[k]), 32'(cfg_nc(k) + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          edges;
        int          cnt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsub;

        resetn = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(rdy), 32'hF);
        check("rst_done",  32'(dn), 32'h0);
        check("rst_sum",   {16'h0, s0}, 32'h0);
        check("rst_cout",  32'(co), 32'h0);
        check("rst_ovf",   32'(ov), 32'h0);
        resetn = 1'b1;

        // Directed vectors on the 16/4 instance
        run_op(1'b0, 32'h0000_FFFF, 32'h0000_0001);
        check_main("add_ffff_1", 16'h0000, 1'b1, 1'b0);
        check("done_width", 32'(dcnt[0]), 32'd1);
        run_op(1'b0, 32'h0000_7FFF, 32'h0000_0001);
        check_main("add_7fff_1", 16'h8000, 1'b0, 1'b1);
        run_op(1'b1, 32'h0000_8000, 32'h0000_0001);
        check_main("sub_8000_1", 16'h7FFF, 1'b1, 1'b1);
        run_op(1'b1, 32'h0000_0005, 32'h0000_0007);
        check_main("sub_5_7", 16'hFFFE, 1'b0, 1'b0);
        run_op(1'b1, 32'h0000_1234, 32'h0000_1234);
        check_main("sub_1234", 16'h0000, 1'b1, 1'b0);
        check("hold_sum", {16'h0, s0}, 32'h0000);

        // start held high with changing operands throughout RUN must be ignored
        wait_all_ready();
        start = 1'b1;
        sub   = 1'b0;
        op_a  = 32'h0000_1111;
        op_b  = 32'h0000_2222;
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        while (!dn[0] && edges < 20) begin
            op_a = $urandom;
            op_b = $urandom;
            sub  = 1'($urandom);
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        check("ign_lat",  32'(edges), 32'd5);
        check("ign_sum",  {16'h0, s0}, 32'h3333);
        check("ign_cout", 32'(co[0]), 32'h0);
        check("ign_ovf",  32'(ov[0]), 32'h0);
        // back-to-back start during the done cycle
        sub  = 1'b1;
        op_a = 32'h0000_00FF;
        op_b = 32'h0000_0001;
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        start = 1'b0;
        check("b2b_done_fall", 32'(dn[0]), 32'h0);
        check("b2b_ready_low", 32'(rdy[0]), 32'h0);
        while (!dn[0] && edges < 20) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        check("b2b_lat",  32'(edges), 32'd5);
        check("b2b_sum",  {16'h0, s0}, 32'h00FE);
        check("b2b_cout", 32'(co[0]), 32'h1);
        check("b2b_ovf",  32'(ov[0]), 32'h0);

        // Asynchronous reset at E2 of an operation
        wait_all_ready();
        start = 1'b1;
        sub   = 1'b0;
        op_a  = 32'h0000_1111;
        op_b  = 32'h0000_2222;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_ready", 32'(rdy[0]), 32'h1);
        check("arst_done",  32'(dn[0]), 32'h0);
        check("arst_sum",   {16'h0, s0}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (dn[0]) cnt++;
        end
        check("arst_no_done", 32'(cnt), 32'h0);
        run_op(1'b0, 32'h0000_00AB, 32'h0000_0101);
        check_main("post_rst", 16'h01AC, 1'b0, 1'b0);

        // Randomized sweep across all configurations against the reference model
        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rsub = 1'(i % 2);
            run_op(rsub, ra, rb);
            for (int k = 0; k < 4; k++) check_model(k, rsub, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder/subtractor, successor to the lab 4-bit ripple-carry adder. It computes A+B or A−B on WIDTH-bit operands, CHUNK bits per clock, through a CHUNK-bit ripple chain with a registered carry between chunks. A start/ready/done handshake lets it sit behind the switch/key front-end or a later datapath controller, trading latency for a short combinational path at large WIDTH.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK, the number of compute cycles.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- sub  in  1  0 = A+B, 1 = A−B; captured with start.
- op_a  in  WIDTH  operand A; captured with start.
- op_b  in  WIDTH  operand B; captured with start.
- ready  out  1  high when a new start will be accepted.
- done  out  1  one-cycle pulse: results valid.
- sum  out  WIDTH  result, held until the next accepted start.
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow, A ≥ B unsigned).
- ovf  out  1  signed overflow, carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE (ready=1), RUN (ready=0), DONE (ready=1, done=1).
- IDLE or DONE, start=1: capture op_a, op_b XOR {WIDTH{sub}}, and carry = sub. Clear chunk index. Go to RUN.
- IDLE or DONE, start=0: DONE → IDLE; IDLE stays IDLE.
- RUN, each cycle: add chunk[idx] of A, B' and carry. Write CHUNK result bits into sum[idx]. Register the carry. Increment idx.
- RUN, at idx = NCHUNK−1: latch cout and ovf from the final chunk. Go to DONE.
- start in RUN is ignored. sub and operands are not re-sampled mid-operation.
- sum, cout and ovf change only during RUN updates. Between operations they hold the last result.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (asynchronous, any state): state=IDLE, ready=1, done=0, sum=0, cout=0, ovf=0, idx=0. An operation in flight is discarded with no done pulse.
- Start accepted at edge E0, so ready=0 from E0.
- Chunks are computed at edges E1…E_NCHUNK.
- done=1 and ready=1 for the cycle after E_NCHUNK. Latency from accepting edge to done is NCHUNK+1 edges.
- Back-to-back: start=1 during the done cycle is accepted at that edge. done then falls and a new RUN begins, so throughput is one result per NCHUNK+1 cycles.
- The partial sum is visible on sum during RUN. Consumers must use it only when done=1.
- CHUNK=WIDTH: NCHUNK=1, so done follows start by 2 edges.

## Structure
- Shared package/header multicycle_adder_pkg: state encodings (ST_IDLE, ST_RUN, ST_DONE, 2 bits) and the index-width rule clog2(NCHUNK), minimum 1.
- One sub-module, chunk_adder (parameter N = CHUNK): a combinational N-bit ripple chain. It outputs the N-bit sum, the carry out and the carry into its MSB, the last two used for ovf.
- Top level: FSM, operand/result shift or indexed registers, carry flop.

## Test plan
- WIDTH=16, CHUNK=4, add 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0. done exactly 5 edges after the accepting edge, high for 1 cycle.
- Add 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1. Sub 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Sub 0x0005−0x0007 → sum=0xFFFE, cout=0, ovf=0. Sub 0x1234−0x1234 → sum=0x0000, cout=1, ovf=0.
- Pulse start with new operands on every cycle of RUN → ignored, result matches the first operands. Then assert start in the done cycle → second operation accepted, second done 5 edges later.
- Drop resetn asynchronously at E2 of an operation → ready=1, done=0, sum=0 immediately. No done pulse follows, and the next start completes normally.
- Sweep configs (8,1), (16,16), (32,8) with random operands against a reference model of A±B mod 2^WIDTH, checking sum, cout, ovf and latency NCHUNK+1.
